// File: rtl/ofdm_tx_pkg.sv
// Shared constants and types for the OFDM transmit pilot inserter:
// sample packing, control state encoding and pilot PN generator settings.
package ofdm_tx_pkg;

    // Packing of one complex subcarrier in a 32-bit beat
    localparam int I_MSB = 31;
    localparam int I_LSB = 16;
    localparam int Q_MSB = 15;
    localparam int Q_LSB = 0;

    // Symbol framing state
    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Pilot scrambler: Fibonacci LFSR for x^7 + x^4 + 1 (taps on bits 6 and 3)
    localparam int             LFSR_W    = 7;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h48;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h7F;

endpackage

// File: rtl/ofdm_pilot_inserter_if.sv
// Avalon-ST stream (ready latency 0, SOP/EOP framing).
// master drives the beat, slave returns ready.
interface ofdm_pilot_inserter_if #(
    parameter int DW = 32
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          startofpacket;
    logic          endofpacket;

    modport master (
        output data, valid, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket,
        output ready
    );
endinterface

// File: rtl/ofdm_pilot_pn_lfsr.sv
// Per-symbol pilot polarity generator: 7-bit LFSR (x^7+x^4+1) seeded with
// 7'h7F, advanced once per output symbol. pn_bit = 1 means negate pilots.
module ofdm_pilot_pn_lfsr
    import ofdm_tx_pkg::*;
(
    input  logic clock_clk,
    input  logic reset_reset_n,
    input  logic step,
    output logic pn_bit
);

    logic [LFSR_W-1:0] lfsr;

    // Shift in the tap parity once per symbol
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            lfsr <= LFSR_SEED;
        end else if (step) begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign pn_bit = lfsr[LFSR_W-1];

endmodule

// File: rtl/ofdm_pilot_inserter.sv
// OFDM TX pilot inserter: merges a stream of data subcarriers with comb
// pilots (every PILOT_SPACING-th index) into framed N_SC-beat symbols.
// Optional build macro OFDM_PILOT_PN_EN: per-symbol pilot polarity from a
// 7-bit LFSR; when undefined, pilots are always (PILOT_I, PILOT_Q).
module ofdm_pilot_inserter
    import ofdm_tx_pkg::*;
#(
    parameter int                 N_SC          = 64,
    parameter int                 PILOT_SPACING = 8,
    parameter logic signed [15:0] PILOT_I       = 16'sd8192,
    parameter logic signed [15:0] PILOT_Q       = 16'sd0
) (
    input  logic                  clock_clk,
    input  logic                  reset_reset_n,
    ofdm_pilot_inserter_if.slave  asi_in0,
    ofdm_pilot_inserter_if.master aso_out0,
    output logic                  framing_err
);

    localparam int IW     = $clog2(N_SC);
    localparam int N_DATA = N_SC - N_SC / PILOT_SPACING;

    localparam logic [IW-1:0] LAST_SC   = IW'(N_SC - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(N_DATA - 1);
    localparam logic [IW-1:0] SLOT_MASK = IW'(PILOT_SPACING - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] sc_idx, sc_idx_nxt;
    logic [IW-1:0] data_cnt, data_cnt_nxt;

    logic [31:0]   out_data;
    logic          out_valid, out_sop, out_eop;

    logic          load_ok;
    logic          pilot_slot;
    logic          in_ready;
    logic          load_en;
    logic [31:0]   load_data;
    logic          load_sop, load_eop;
    logic          err_set;

    logic [15:0]   pilot_i, pilot_q;
    logic [31:0]   pilot;

`ifdef OFDM_PILOT_PN_EN
    logic pn_neg;

    ofdm_pilot_pn_lfsr u_pn_lfsr (
        .clock_clk     (clock_clk),
        .reset_reset_n (reset_reset_n),
        .step          (load_en && load_eop),
        .pn_bit        (pn_neg)
    );

    assign pilot_i = pn_neg ? -PILOT_I : PILOT_I;
    assign pilot_q = pn_neg ? -PILOT_Q : PILOT_Q;
`else
    assign pilot_i = PILOT_I;
    assign pilot_q = PILOT_Q;
`endif

    // Pack the pilot subcarrier into beat layout
    always_comb begin
        pilot                = '0;
        pilot[I_MSB:I_LSB]   = pilot_i;
        pilot[Q_MSB:Q_LSB]   = pilot_q;
    end

    // The output register may take a new beat when empty or being drained
    assign load_ok    = !out_valid || aso_out0.ready;
    assign pilot_slot = (sc_idx & SLOT_MASK) == '0;

    // Next-state, input ready, output-register load and framing checks
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_nxt    = state;
        sc_idx_nxt   = sc_idx;
        data_cnt_nxt = data_cnt;
        in_ready     = 1'b0;
        load_en      = 1'b0;
        load_data    = '0;
        load_sop     = 1'b0;
        load_eop     = 1'b0;
        err_set      = 1'b0;

        case (state)
            IDLE: begin
                if (asi_in0.valid) begin
                    if (!asi_in0.startofpacket) begin
                        // Beat outside a symbol: swallow it and flag
                        in_ready = 1'b1;
                        err_set  = 1'b1;
                    end else if (load_ok) begin
                        // SOP stays on the bus; emit pilot 0 first
                        load_en      = 1'b1;
                        load_data    = pilot;
                        load_sop     = 1'b1;
                        sc_idx_nxt   = IW'(1);
                        data_cnt_nxt = '0;
                        state_nxt    = RUN;
                    end
                end
            end

            RUN: begin
                if (pilot_slot) begin
                    if (load_ok) begin
                        load_en   = 1'b1;
                        load_data = pilot;
                    end
                end else begin
                    in_ready = load_ok;
                    if (asi_in0.valid && load_ok) begin
                        load_en      = 1'b1;
                        load_data    = asi_in0.data;
                        data_cnt_nxt = data_cnt + 1'b1;
                        if (asi_in0.startofpacket && data_cnt != '0)
                            err_set = 1'b1;
                        if (asi_in0.endofpacket != (data_cnt == LAST_DATA))
                            err_set = 1'b1;
                    end
                end

                if (load_en) begin
                    if (sc_idx == LAST_SC) begin
                        load_eop   = 1'b1;
                        sc_idx_nxt = '0;
                        state_nxt  = IDLE;
                    end else begin
                        sc_idx_nxt = sc_idx + 1'b1;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Control state register
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_reset_n) begin
            state    <= IDLE;
            sc_idx   <= '0;
            data_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sc_idx   <= sc_idx_nxt;
            data_cnt <= data_cnt_nxt;
        end
    end

    // Single output beat register; holds while valid and not ready
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else if (load_ok) begin
            out_valid <= load_en;
            if (load_en) begin
                out_data <= load_data;
                out_sop  <= load_sop;
                out_eop  <= load_eop;
            end
        end
    end

    // Sticky framing error, cleared only by reset
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            framing_err <= 1'b0;
        end else if (err_set) begin
            framing_err <= 1'b1;
        end
    end

    assign asi_in0.ready          = in_ready;
    assign aso_out0.valid         = out_valid;
    assign aso_out0.data          = out_data;
    assign aso_out0.startofpacket = out_sop;
    assign aso_out0.endofpacket   = out_eop;

endmodule

// File: tb/tb_ofdm_pilot_inserter.sv
// Directed self-checking bench for ofdm_pilot_inserter (N_SC=64, spacing 8).
// Expected symbols are built from the data index and the pilot constant;
// with OFDM_PILOT_PN_EN the pilot sign follows a bench-side LFSR model.
module tb_ofdm_pilot_inserter;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } beat_t;

    logic clock_clk = 1'b0;
    logic reset_reset_n;
    logic framing_err;

    ofdm_pilot_inserter_if #(.DW(32)) asi_in0 ();
    ofdm_pilot_inserter_if #(.DW(32)) aso_out0 ();

    ofdm_pilot_inserter dut (
        .clock_clk     (clock_clk),
        .reset_reset_n (reset_reset_n),
        .asi_in0       (asi_in0),
        .aso_out0      (aso_out0),
        .framing_err   (framing_err)
    );

    always #5 clock_clk = ~clock_clk;

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    sop_cyc     = 0;
    int    n_sym       = 0;
    int    stall_cnt   = 0;
    int    ready_mode  = 0;
    beat_t got[$];
    int    got_cyc[$];
    logic  held = 1'b0;
    beat_t held_beat;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] exp_pilot(input int sym);
        logic [6:0] s   = 7'h7F;
        logic       neg = 1'b0;
        for (int i = 0; i < sym; i++) s = {s[5:0], s[6] ^ s[3]};
`ifdef OFDM_PILOT_PN_EN
        neg = s[6];
`endif
        return neg ? 32'hE000_0000 : 32'h2000_0000;
    endfunction

    always @(posedge clock_clk) cyc <= cyc + 1;

    // Sink ready: always 1, or toggling every cycle
    always @(posedge clock_clk) begin
        #1;
        if (ready_mode == 1) aso_out0.ready = ~aso_out0.ready;
        else                 aso_out0.ready = 1'b1;
    end

    // Output monitor: record accepted beats, check stability under stall
    always @(negedge clock_clk) begin
        beat_t cur;
        cur = {aso_out0.startofpacket, aso_out0.endofpacket, aso_out0.data};
        if (!reset_reset_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", 64'(aso_out0.valid), 64'(1));
                check("stall_beat", 64'(cur), 64'(held_beat));
            end
            if (aso_out0.valid === 1'b1 && aso_out0.ready === 1'b1) begin
                got.push_back(cur);
                got_cyc.push_back(cyc);
            end
            held      = (aso_out0.valid === 1'b1) && (aso_out0.ready === 1'b0);
            held_beat = cur;
            if (held) stall_cnt++;
        end
    end

    task automatic src_idle();
        asi_in0.valid         = 1'b0;
        asi_in0.startofpacket = 1'b0;
        asi_in0.endofpacket   = 1'b0;
        asi_in0.data          = '0;
    endtask

    // Present one beat (called at posedge+1), return at posedge+1 after acceptance
    task automatic send_beat(input logic [31:0] d, input logic s, input logic e);
        int n = 0;
        asi_in0.data          = d;
        asi_in0.valid         = 1'b1;
        asi_in0.startofpacket = s;
        asi_in0.endofpacket   = e;
        if (s) sop_cyc = cyc;
        @(negedge clock_clk);
        while (asi_in0.ready !== 1'b1) begin
            n++;
            if (n > 200) begin
                check("src_timeout", 64'(asi_in0.ready), 64'(1));
                break;
            end
            @(negedge clock_clk);
        end
        @(posedge clock_clk);
        #1;
    endtask

    task automatic send_symbol(input logic [31:0] base, input int eop_at);
        for (int i = 0; i < 56; i++)
            send_beat(base + 32'(i), i == 0, i == eop_at);
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (got.size() < n && t < 2000) begin
            @(negedge clock_clk);
            t++;
        end
        check("beat_count", 64'(got.size()), 64'(n));
    endtask

    task automatic check_symbol(input int start, input logic [31:0] base);
        for (int k = 0; k < 64; k++) begin
            beat_t exp;
            exp.sop  = (k == 0);
            exp.eop  = (k == 63);
            exp.data = (k % 8 == 0) ? exp_pilot(n_sym) : base + 32'(k - k / 8 - 1);
            check($sformatf("sym%0d_idx%0d", n_sym, k), 64'(got[start + k]), 64'(exp));
        end
        n_sym++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(aso_out0.valid), 64'(0));
        check({tag, "_data"},  64'(aso_out0.data), 64'(0));
        check({tag, "_sop"},   64'(aso_out0.startofpacket), 64'(0));
        check({tag, "_eop"},   64'(aso_out0.endofpacket), 64'(0));
        check({tag, "_ferr"},  64'(framing_err), 64'(0));
    endtask

    task automatic do_reset();
        src_idle();
        reset_reset_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        check("reset_in_ready", 64'(asi_in0.ready), 64'(0));
        @(negedge clock_clk);
        reset_reset_n = 1'b1;
        @(posedge clock_clk);
        #1;
        n_sym = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        aso_out0.ready = 1'b1;
        src_idle();
        reset_reset_n = 1'b0;
        #12;
        do_reset();

        // 1: always-ready source and sink, data = index
        s = got.size();
        send_symbol(32'h0, 55);
        src_idle();
        wait_beats(s + 64);
        check("first_latency", 64'(got_cyc[s] - sop_cyc), 64'(1));
        check_symbol(s, 32'h0);
        check("ferr_clean", 64'(framing_err), 64'(0));

        // 2: sink ready toggling every cycle
        ready_mode = 1;
        stall_cnt  = 0;
        s = got.size();
        send_symbol(32'h0, 55);
        src_idle();
        wait_beats(s + 64);
        check_symbol(s, 32'h0);
        check("stalls_seen", 64'(stall_cnt > 0), 64'(1));
        ready_mode = 0;
        repeat (2) @(posedge clock_clk);
        #1;

        // 3: two back-to-back symbols
        s = got.size();
        send_symbol(32'h100, 55);
        send_symbol(32'h200, 55);
        src_idle();
        wait_beats(s + 128);
        check_symbol(s, 32'h100);
        check_symbol(s + 64, 32'h200);
        check("b2b_gap", 64'((got_cyc[s + 64] - got_cyc[s + 63]) <= 2), 64'(1));

        // 4: three beats without SOP are dropped, then a normal symbol
        s = got.size();
        send_beat(32'hDEAD_0001, 1'b0, 1'b0);
        send_beat(32'hDEAD_0002, 1'b0, 1'b0);
        send_beat(32'hDEAD_0003, 1'b0, 1'b0);
        src_idle();
        repeat (3) @(negedge clock_clk);
        check("drop_no_output", 64'(got.size()), 64'(s));
        check("drop_ferr", 64'(framing_err), 64'(1));
        @(posedge clock_clk);
        #1;
        send_symbol(32'h300, 55);
        src_idle();
        wait_beats(s + 64);
        check_symbol(s, 32'h300);

        // 5: early EOP at data_cnt 40
        do_reset();
        s = got.size();
        send_symbol(32'h400, 40);
        src_idle();
        wait_beats(s + 64);
        check_symbol(s, 32'h400);
        check("early_eop_ferr", 64'(framing_err), 64'(1));

        // 6: eight symbols from reset (pilot polarity sequence)
        do_reset();
        s = got.size();
        for (int i = 0; i < 8; i++) send_symbol(32'h1000 * 32'(i + 1), 55);
        src_idle();
        wait_beats(s + 512);
        for (int i = 0; i < 8; i++) check_symbol(s + 64 * i, 32'h1000 * 32'(i + 1));

        // 7: reset asserted mid-symbol, then a clean symbol
        send_beat(32'hBAD0_0000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) send_beat(32'h5000 + 32'(i), i == 0, 1'b0);
        check("pre_reset_ferr", 64'(framing_err), 64'(1));
        src_idle();
        #2;
        reset_reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clock_clk);
        reset_reset_n = 1'b1;
        @(posedge clock_clk);
        #1;
        n_sym = 0;
        s = got.size();
        send_symbol(32'h6000, 55);
        src_idle();
        wait_beats(s + 64);
        check_symbol(s, 32'h6000);
        check("post_reset_ferr", 64'(framing_err), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ofdm_pilot_inserter.md
Name: ofdm_pilot_inserter

Overview:
- Transmit-side counterpart of the receive-chain channel equalizer.
- Takes a stream of frequency-domain data subcarriers (16b I / 16b Q), one input packet per OFDM symbol, and inserts pilot subcarriers at fixed comb positions.
- Emits one framed output packet of N_SC subcarriers per symbol to the TX IFFT.
- Both sides are Avalon-ST, ready latency 0, with SOP/EOP.

Parameters:
- N_SC, 64, subcarriers per output symbol; power of two, 16..1024.
- PILOT_SPACING, 8, a pilot sits at every index k with k % PILOT_SPACING == 0; power of two, divides N_SC.
- PILOT_I, 16'sd8192, pilot real part, signed.
- PILOT_Q, 16'sd0, pilot imaginary part, signed.
- Derived constant N_DATA = N_SC - N_SC/PILOT_SPACING (default 56).

Ports:
- clock_clk  in  1  sole clock; all logic is rising-edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- asi_in0_data  in  32  data subcarrier: [31:16] I, [15:0] Q, both signed.
- asi_in0_valid  in  1  input beat valid.
- asi_in0_ready  out  1  input beat accepted when valid && ready.
- asi_in0_startofpacket  in  1  first data subcarrier of a symbol.
- asi_in0_endofpacket  in  1  last data subcarrier of a symbol.
- aso_out0_data  out  32  output subcarrier, same packing as the input.
- aso_out0_valid  out  1  output beat valid.
- aso_out0_ready  in  1  sink ready.
- aso_out0_startofpacket  out  1  asserted on subcarrier index 0.
- aso_out0_endofpacket  out  1  asserted on subcarrier index N_SC-1.
- framing_err  out  1  sticky flag for input framing violations.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - aso_out0_valid=0, data=0, SOP=0, EOP=0, framing_err=0.
  - State IDLE, sc_idx=0, data_cnt=0.
- Output register: a single registered beat.
  - load_ok = !aso_out0_valid || aso_out0_ready.
  - The register holds its contents while valid && !ready (AXI/Avalon stability rule).
- IDLE:
  - asi_in0_ready=1 only for a valid beat without SOP. Such a beat is consumed and dropped, and framing_err is set.
  - A valid beat with SOP is not consumed in IDLE. When load_ok, the block loads pilot index 0 (SOP=1), sets sc_idx=1, data_cnt=0 and moves to RUN.
  - Latency: the first output beat is valid 1 cycle after the SOP beat is presented.
- RUN, pilot slot (sc_idx % PILOT_SPACING == 0):
  - asi_in0_ready=0.
  - When load_ok, load the pilot and increment sc_idx.
- RUN, data slot:
  - asi_in0_ready = load_ok.
  - On a handshake, load the input data, increment sc_idx and data_cnt.
- Framing checks in RUN:
  - An input SOP on data_cnt != 0 sets framing_err; the data is still used.
  - An input EOP on data_cnt != N_DATA-1 sets framing_err.
  - If data_cnt == N_DATA-1 is accepted without EOP, framing_err is set.
  - The symbol always completes with exactly N_SC beats.
- The beat loaded at sc_idx == N_SC-1 carries EOP=1. Then sc_idx wraps to 0 and the state returns to IDLE. No bubble is added beyond IDLE's single-cycle SOP check.
- Throughput: 1 beat/cycle sustained when source and sink are always ready. The input is stalled for 1 cycle per pilot.
- framing_err is cleared only by reset.

Optional Feature:
- Macro OFDM_PILOT_PN_EN.
- Defined:
  - A 7-bit LFSR (x^7+x^4+1, seed 7'h7F on reset) advances once per output symbol, at EOP load.
  - While the LFSR output bit is 1, both pilot components of that symbol are negated (two's complement).
- Undefined: pilots are always (PILOT_I, PILOT_Q) and no LFSR is present.

Decomposition:
- Package ofdm_tx_pkg holds:
  - sample packing constants (I_MSB=31, I_LSB=16, Q_MSB=15, Q_LSB=0);
  - the state enum {IDLE, RUN};
  - the LFSR polynomial and seed constants.
- One sub-module: ofdm_pilot_pn_lfsr, instantiated only under OFDM_PILOT_PN_EN.

Test Plan:
- Always-ready source and sink, 56 beats with data = index, SOP/EOP correct:
  - 64 outputs.
  - Index 0, 8, …, 56 = 32'h2000_0000.
  - Index 1 = 32'h0000_0000 and index 63 = 32'h0000_0037.
  - SOP only at idx0, EOP only at idx63, framing_err=0.
- Sink ready toggled 1/0 every cycle:
  - Output data is stable during stalls.
  - The output sequence is identical to the always-ready case.
- Two back-to-back symbols:
  - 128 beats with no beat lost.
  - The second SOP follows the first EOP after at most 1 idle cycle.
- Three input beats without SOP, then a normal symbol:
  - The 3 beats are dropped and framing_err=1.
  - The following symbol is output correctly.
- Input EOP at data_cnt=40:
  - framing_err=1.
  - The output still delivers 64 beats ending with EOP.
- With OFDM_PILOT_PN_EN defined, 8 symbols:
  - Pilot I follows the LFSR sequence from seed 7'h7F (±8192).
  - Without the macro, pilot I is always 8192.
- Reset asserted mid-symbol: all outputs are 0 immediately, and the next SOP starts a clean symbol.
